// File: rtl/point_add_arbiter.sv
// Round-robin arbiter sharing one point_add unit between two requesters,
// with a watchdog that aborts a hung operation and reports it via rsp_err.
module point_add_arbiter #(
  parameter int unsigned W       = 256,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  input  logic [2*W-1:0] req_x1,
  input  logic [2*W-1:0] req_y1,
  input  logic [1:0]     req_inf1,
  input  logic [2*W-1:0] req_x2,
  input  logic [2*W-1:0] req_y2,
  input  logic [1:0]     req_inf2,
  output logic [1:0]     req_ready,
  output logic [1:0]     rsp_done,
  output logic [W-1:0]   rsp_x3,
  output logic [W-1:0]   rsp_y3,
  output logic           rsp_inf3,
  output logic           rsp_err,
  output logic           busy,
  output logic           pa_start,
  output logic [W-1:0]   pa_x1,
  output logic [W-1:0]   pa_y1,
  output logic [W-1:0]   pa_x2,
  output logic [W-1:0]   pa_y2,
  output logic           pa_inf1,
  output logic           pa_inf2,
  input  logic           pa_done,
  input  logic [W-1:0]   pa_x3,
  input  logic [W-1:0]   pa_y3,
  input  logic           pa_inf3
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_n;
  logic            last_grant;
  logic            grant;
  logic            grant_c;
  logic            accept_c;
  logic            rise_c;
  logic            timeout_c;
  logic            pa_done_q;
  logic [CW-1:0]   wdog;

  // Both valid: the side not served last wins; otherwise the only valid side.
  assign grant_c   = req_valid[1] & (~req_valid[0] | ~last_grant);
  assign accept_c  = |req_valid;
  assign rise_c    = pa_done & ~pa_done_q;
  assign timeout_c = (wdog == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 2'b00;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          req_ready = grant_c ? 2'b10 : 2'b01;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (rise_c || timeout_c) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: operand latch, watchdog, result capture and response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      pa_done_q  <= 1'b0;
      wdog       <= '0;
      pa_start   <= 1'b0;
      busy       <= 1'b0;
      rsp_done   <= 2'b00;
      rsp_x3     <= '0;
      rsp_y3     <= '0;
      rsp_inf3   <= 1'b1;
      rsp_err    <= 1'b0;
      pa_x1      <= '0;
      pa_y1      <= '0;
      pa_x2      <= '0;
      pa_y2      <= '0;
      pa_inf1    <= 1'b0;
      pa_inf2    <= 1'b0;
    end else begin
      pa_done_q <= pa_done;
      pa_start  <= (state_n == S_ISSUE);
      busy      <= (state_n != S_IDLE);
      rsp_done  <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (accept_c) begin
            grant   <= grant_c;
            pa_x1   <= grant_c ? req_x1[W +: W] : req_x1[0 +: W];
            pa_y1   <= grant_c ? req_y1[W +: W] : req_y1[0 +: W];
            pa_x2   <= grant_c ? req_x2[W +: W] : req_x2[0 +: W];
            pa_y2   <= grant_c ? req_y2[W +: W] : req_y2[0 +: W];
            pa_inf1 <= grant_c ? req_inf1[1] : req_inf1[0];
            pa_inf2 <= grant_c ? req_inf2[1] : req_inf2[0];
          end
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (rise_c) begin
            rsp_x3   <= pa_x3;
            rsp_y3   <= pa_y3;
            rsp_inf3 <= pa_inf3;
            rsp_err  <= 1'b0;
            rsp_done <= grant ? 2'b10 : 2'b01;
          end else if (timeout_c) begin
            rsp_x3   <= '0;
            rsp_y3   <= '0;
            rsp_inf3 <= 1'b1;
            rsp_err  <= 1'b1;
            rsp_done <= grant ? 2'b10 : 2'b01;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
        S_RESP:  last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_add_arbiter.sv
// Bench for point_add_arbiter: fixed/random-latency point_add stub, round-robin
// reference model, watchdog, stale-done and mid-operation reset scenarios.
module tb_point_add_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [2*W-1:0] req_x1 = '0, req_y1 = '0, req_x2 = '0, req_y2 = '0;
  logic [1:0]     req_inf1 = 2'b00, req_inf2 = 2'b00;
  logic [1:0]     req_ready, rsp_done;
  logic [W-1:0]   rsp_x3, rsp_y3;
  logic           rsp_inf3, rsp_err, busy, pa_start;
  logic [W-1:0]   pa_x1, pa_y1, pa_x2, pa_y2;
  logic           pa_inf1, pa_inf2;
  logic           pa_done = 1'b0;
  logic [W-1:0]   pa_x3 = '0, pa_y3 = '0;
  logic           pa_inf3 = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_last = 1;

  logic [W-1:0] ox1 [2], oy1 [2], ox2 [2], oy2 [2];
  logic         oi1 [2], oi2 [2];

  point_add_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_x1(req_x1), .req_y1(req_y1), .req_inf1(req_inf1),
    .req_x2(req_x2), .req_y2(req_y2), .req_inf2(req_inf2),
    .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_x3(rsp_x3), .rsp_y3(rsp_y3), .rsp_inf3(rsp_inf3), .rsp_err(rsp_err),
    .busy(busy), .pa_start(pa_start),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_x2(pa_x2), .pa_y2(pa_y2),
    .pa_inf1(pa_inf1), .pa_inf2(pa_inf2),
    .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // point_add stub: done rises L cycles after start; result = {x1+x2, y1^y2, inf1&inf2}
  int           st_lat   = 10;
  bit           st_never = 1'b0;
  bit           st_hold  = 1'b0;
  int           st_cnt   = 0;
  bit           st_act   = 1'b0;
  logic [W-1:0] sx1 = '0, sy1 = '0, sx2 = '0, sy2 = '0;
  logic         si1 = 1'b0, si2 = 1'b0;

  always @(posedge clk) begin
    if (pa_start) begin
      st_act <= 1'b1;
      st_cnt <= st_lat - 1;
      sx1 <= pa_x1; sy1 <= pa_y1; sx2 <= pa_x2; sy2 <= pa_y2;
      si1 <= pa_inf1; si2 <= pa_inf2;
      if (!st_hold) pa_done <= 1'b0;
    end else if (st_act && st_cnt == 1) begin
      st_act <= 1'b0;
      if (!st_never) begin
        pa_done <= 1'b1;
        pa_x3   <= sx1 + sx2;
        pa_y3   <= sy1 ^ sy2;
        pa_inf3 <= si1 & si2;
      end
    end else begin
      if (st_act) st_cnt <= st_cnt - 1;
      if (!st_hold) pa_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    req_x1[i*W +: W] = ox1[i];
    req_y1[i*W +: W] = oy1[i];
    req_x2[i*W +: W] = ox2[i];
    req_y2[i*W +: W] = oy2[i];
    req_inf1[i]      = oi1[i];
    req_inf2[i]      = oi2[i];
  endtask

  task automatic set_ops(input int i);
    ox1[i] = W'($urandom);
    oy1[i] = W'($urandom);
    ox2[i] = W'($urandom);
    oy2[i] = W'($urandom);
    oi1[i] = ($urandom_range(0, 3) == 0);
    oi2[i] = ($urandom_range(0, 3) == 0);
    drive(i);
  endtask

  // One complete transaction from the IDLE cycle; called at a negedge.
  task automatic serve(input logic [1:0] mask, input bit keep, input bit exp_err,
                       input int release_after);
    int g, t, lat;
    logic [1:0] oh;
    logic [W-1:0] ex1, ey1, ex2, ey2, ex3, ey3;
    logic ei1, ei2, einf;
    g   = (mask == 2'b11) ? 1 - model_last : (mask[1] ? 1 : 0);
    oh  = (g == 1) ? 2'b10 : 2'b01;
    lat = exp_err ? int'(TO) + 2 : st_lat + 2;
    ex1 = ox1[g]; ey1 = oy1[g]; ex2 = ox2[g]; ey2 = oy2[g];
    ei1 = oi1[g]; ei2 = oi2[g];
    ex3  = exp_err ? '0 : ex1 + ex2;
    ey3  = exp_err ? '0 : ey1 ^ ey2;
    einf = exp_err ? 1'b1 : (ei1 & ei2);
    req_valid = mask;
    #1;
    t = cyc;
    while (req_ready == 2'b00 && cyc - t < 40) begin
      @(negedge clk);
      #1;
    end
    chk("req_ready", W'(req_ready), W'(oh));
    t = cyc;
    @(negedge clk);
    chk("pa_start", W'(pa_start), W'(1));
    chk("pa_x1", pa_x1, ex1);
    chk("pa_y1", pa_y1, ey1);
    chk("pa_x2", pa_x2, ex2);
    chk("pa_y2", pa_y2, ey2);
    chk("pa_inf", W'({pa_inf1, pa_inf2}), W'({ei1, ei2}));
    chk("req_ready_one_cycle", W'(req_ready), W'(0));
    set_ops(g);
    if (!keep) req_valid = 2'b00;
    for (int k = 0; k < release_after; k++) begin
      @(negedge clk);
      chk("no_early_done", W'(rsp_done), W'(0));
    end
    if (release_after > 0) st_hold = 1'b0;
    while (rsp_done == 2'b00 && cyc - t < 60) @(negedge clk);
    chk("latency", W'(cyc - t), W'(lat));
    chk("rsp_done", W'(rsp_done), W'(oh));
    chk("rsp_err", W'(rsp_err), W'(exp_err));
    chk("rsp_x3", rsp_x3, ex3);
    chk("rsp_y3", rsp_y3, ey3);
    chk("rsp_inf3", W'(rsp_inf3), W'(einf));
    chk("busy_resp", W'(busy), W'(1));
    model_last = g;
    @(negedge clk);
    chk("done_pulse", W'(rsp_done), W'(0));
    chk("busy_idle", W'(busy), W'(0));
    chk("rsp_x3_hold", rsp_x3, ex3);
  endtask

  initial begin
    set_ops(0);
    set_ops(1);
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_pa_start", W'(pa_start), W'(0));
    chk("rst_rsp_done", W'(rsp_done), W'(0));
    chk("rst_rsp_inf3", W'(rsp_inf3), W'(1));
    chk("rst_rsp_err", W'(rsp_err), W'(0));
    chk("rst_rsp_x3", rsp_x3, '0);
    chk("rst_pa_x1", pa_x1, '0);
    chk("rst_req_ready", W'(req_ready), W'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed single request with known operands
    ox1[0] = W'(1); oy1[0] = W'(2); ox2[0] = W'(3); oy2[0] = W'(4);
    oi1[0] = 1'b0; oi2[0] = 1'b0;
    drive(0);
    serve(2'b01, 1'b0, 1'b0, 0);
    chk("directed_x3", rsp_x3, W'(4));
    chk("directed_y3", rsp_y3, W'(6));

    // Reset-fresh contention, then persistent contention must alternate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
    @(negedge clk);
    serve(2'b11, 1'b1, 1'b0, 0);
    chk("first_grant_is_0", W'(model_last), W'(0));
    for (int i = 0; i < 6; i++) serve(2'b11, 1'b1, 1'b0, 0);
    req_valid = 2'b00;

    // Watchdog abort, then normal service
    st_never = 1'b1;
    serve(2'b10, 1'b0, 1'b1, 0);
    st_never = 1'b0;
    serve(2'b10, 1'b0, 1'b0, 0);

    // Done level held from the previous op must not complete the next one
    st_hold = 1'b1;
    serve(2'b01, 1'b0, 1'b0, 0);
    chk("stub_done_held", W'(pa_done), W'(1));
    serve(2'b10, 1'b0, 1'b0, 3);

    // Reset during WAIT discards the operation
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("wait_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_pa_start", W'(pa_start), W'(0));
    chk("mid_rst_rsp_inf3", W'(rsp_inf3), W'(1));
    chk("mid_rst_rsp_x3", rsp_x3, '0);
    chk("mid_rst_pa_x1", pa_x1, '0);
    rst = 1'b0;
    model_last = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("aborted_no_done", W'(rsp_done), W'(0));
    end
    serve(2'b11, 1'b0, 1'b0, 0);

    // Random masks, latencies and hold behaviour
    for (int i = 0; i < 30; i++) begin
      st_lat = $urandom_range(2, 15);
      serve(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
